// File: rtl/dmem_lsu_pkg.sv
// Shared types for the dmem_lsu load/store unit: size encodings, FSM states, mask helpers.
// The ACC1 state only exists when DMEM_LSU_MISALIGN_EN is defined.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
`ifdef DMEM_LSU_MISALIGN_EN
        ST_ACC1 = 2'd2,
`endif
        ST_RESP = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    size_mask = 4'b0001;
            SZ_H:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response and memory-port bundle for dmem_lsu (slave = the LSU, master = CPU/memory side).
// Same signal set with or without DMEM_LSU_MISALIGN_EN.
interface dmem_lsu_if #(parameter int MEM_AW = 15);

    // Handshake: a request transfers on a rising clk edge where req_valid and req_ready are both 1;
    // the requester holds req_* stable until then. resp_valid is a single-cycle pulse, never stalled.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [3:0]        mem_byteena;
    logic              mem_wren;
    logic [31:0]       mem_q;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_data, mem_byteena, mem_wren
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_data, mem_byteena, mem_wren
    );

endinterface

// File: rtl/dmem_lsu_align.sv
// Lane alignment for dmem_lsu: store data/enable shifting and load merge with sign/zero extension.
// The second-word paths are present only when DMEM_LSU_MISALIGN_EN is defined.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo,
`ifdef DMEM_LSU_MISALIGN_EN
    input  logic [31:0] i_hi,
    output logic [31:0] o_data1,
    output logic [3:0]  o_be1,
`endif
    output logic [31:0] o_data0,
    output logic [3:0]  o_be0,
    output logic [31:0] o_rdata
);

    logic [3:0]  w_mask;
    logic [4:0]  w_sh0;
    logic [31:0] w_raw;

    assign w_mask  = size_mask(i_size);
    assign w_sh0   = {i_off, 3'b000};
    assign o_data0 = i_wdata << w_sh0;
    assign o_be0   = w_mask << i_off;

`ifdef DMEM_LSU_MISALIGN_EN
    logic [5:0] w_sh1;
    // Bytes that spill past lane 3 land in the low lanes of the next word.
    assign w_sh1   = 6'd32 - {1'b0, w_sh0};
    assign o_data1 = i_wdata >> w_sh1;
    assign o_be1   = w_mask >> (3'd4 - {1'b0, i_off});
    assign w_raw   = (i_lo >> w_sh0) | (i_hi << w_sh1);
`else
    assign w_raw   = i_lo >> w_sh0;
`endif

    always_comb begin
        o_rdata = w_raw;
        case (i_size)
            SZ_B:    o_rdata = {{24{~i_uns & w_raw[7]}}, w_raw[7:0]};
            SZ_H:    o_rdata = {{16{~i_uns & w_raw[15]}}, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a byte-enabled data memory: one request at a time, registered response.
// Define DMEM_LSU_MISALIGN_EN to execute word-crossing accesses as two memory cycles.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int MEM_AW = 15
) (
    input  logic       clk,
    input  logic       rstn,
    dmem_lsu_if.slave  bus,
    output state_t     o_dbg_state
);

    state_t            r_state, w_next;
    logic              r_we, r_uns, r_err;
    logic [1:0]        r_size, r_off;
    logic [MEM_AW-1:0] r_addr;
    logic [31:0]       r_wdata, r_lo;
    logic              r_resp_valid, r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic              w_accept, w_bad, w_unused_addr;
    logic [31:0]       w_data0, w_rdata;
    logic [3:0]        w_be0;

    assign w_accept      = (r_state == ST_IDLE) && bus.req_valid;
    assign w_unused_addr = ^bus.req_addr[31:MEM_AW+2];

`ifdef DMEM_LSU_MISALIGN_EN
    logic        r_split, w_split;
    logic [31:0] r_hi, w_data1;
    logic [3:0]  w_be1;
    assign w_split = ({1'b0, bus.req_addr[1:0]} + size_bytes(bus.req_size)) > 3'd4;
    assign w_bad   = (bus.req_size == 2'd3);
`else
    assign w_bad   = (bus.req_size == 2'd3)
                   || ((bus.req_size == SZ_H) && bus.req_addr[0])
                   || ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`endif

    dmem_lsu_align u_align (
        .i_off   (r_off),
        .i_size  (r_size),
        .i_uns   (r_uns),
        .i_wdata (r_wdata),
        .i_lo    (r_lo),
`ifdef DMEM_LSU_MISALIGN_EN
        .i_hi    (r_hi),
        .o_data1 (w_data1),
        .o_be1   (w_be1),
`endif
        .o_data0 (w_data0),
        .o_be0   (w_be0),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_err        <= 1'b0;
            r_size       <= 2'd0;
            r_off        <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_lo         <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
`ifdef DMEM_LSU_MISALIGN_EN
            r_split      <= 1'b0;
            r_hi         <= 32'd0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_err   <= w_bad;
                r_size  <= bus.req_size;
                r_off   <= bus.req_addr[1:0];
                r_addr  <= bus.req_addr[MEM_AW+1:2];
                r_wdata <= bus.req_wdata;
`ifdef DMEM_LSU_MISALIGN_EN
                r_split <= w_split;
                r_hi    <= 32'd0;
`endif
            end
            if ((r_state == ST_ACC0) && !r_we) r_lo <= bus.mem_q;
`ifdef DMEM_LSU_MISALIGN_EN
            if ((r_state == ST_ACC1) && !r_we) r_hi <= bus.mem_q;
`endif
            // The response is registered out of RESP, so it appears in the following IDLE cycle.
            r_resp_valid <= (r_state == ST_RESP);
            r_resp_err   <= (r_state == ST_RESP) && r_err;
            r_resp_rdata <= ((r_state == ST_RESP) && !r_err && !r_we) ? w_rdata : 32'd0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.req_valid) w_next = w_bad ? ST_RESP : ST_ACC0;
`ifdef DMEM_LSU_MISALIGN_EN
            ST_ACC0: w_next = r_split ? ST_ACC1 : ST_RESP;
            ST_ACC1: w_next = ST_RESP;
`else
            ST_ACC0: w_next = ST_RESP;
`endif
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr    = r_addr;
        bus.mem_data    = w_data0;
        bus.mem_byteena = 4'b0000;
        bus.mem_wren    = 1'b0;
        case (r_state)
            ST_ACC0: begin
                bus.mem_byteena = w_be0;
                bus.mem_wren    = r_we;
            end
`ifdef DMEM_LSU_MISALIGN_EN
            ST_ACC1: begin
                bus.mem_addr    = r_addr + {{(MEM_AW-1){1'b0}}, 1'b1};
                bus.mem_data    = w_data1;
                bus.mem_byteena = w_be1;
                bus.mem_wren    = r_we;
            end
`endif
            default: ;
        endcase
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: byte-level reference memory, response and write-port scoreboards.
// Honours DMEM_LSU_MISALIGN_EN the same way the RTL does.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int AW = 15;
`ifdef DMEM_LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic   clk;
    logic   rstn;
    state_t dbg_state;
    int unsigned cyc;
    int n_cmp;
    int n_bad;

    dmem_lsu_if #(.MEM_AW(AW)) bus ();

    dmem_lsu #(.MEM_AW(AW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset / memory fixture ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] fmem [0:(1<<AW)-1];
    assign bus.mem_q = fmem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_wren) begin
            for (int l = 0; l < 4; l++)
                if (bus.mem_byteena[l]) fmem[bus.mem_addr][8*l +: 8] <= bus.mem_data[8*l +: 8];
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [7:0]  ref_mem [0:(1<<(AW+2))-1];
    logic [64:0] exp_q[$];   // {err, rdata, due cycle}
    logic [50:0] exp_w[$];   // {word address, byte enables, data}

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int n, t, lat;
        logic err, split;
        logic [31:0] rd;
        logic [16:0] ba;
        logic [AW-1:0] w0, w1;
        logic [3:0]  be0, be1;
        logic [31:0] d0, d1;
        n     = nbytes(sz);
        err   = (sz == 2'd3) || (!MIS && ((addr % n) != 0));
        split = (int'(addr[1:0]) + n) > 4;
        lat   = err ? 1 : (split ? 3 : 2);
        t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_at_issue", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rd = 32'd0;
        if (!err && !we) begin
            for (int i = 0; i < n; i++) begin
                ba = addr[16:0] + 17'(i);
                rd = rd | (32'(ref_mem[ba]) << (8 * i));
            end
            if (!uns && rd[8*n-1]) begin
                for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
            end
        end
        if (!err && we) begin
            w0 = addr[AW+1:2];
            w1 = w0 + 1'b1;
            be0 = 4'd0; be1 = 4'd0; d0 = 32'd0; d1 = 32'd0;
            for (int i = 0; i < n; i++) begin
                ba = addr[16:0] + 17'(i);
                ref_mem[ba] = wdata[8*i +: 8];
                if (ba[16:2] == w0) begin
                    be0[ba[1:0]] = 1'b1;
                    d0[8*ba[1:0] +: 8] = wdata[8*i +: 8];
                end else begin
                    be1[ba[1:0]] = 1'b1;
                    d1[8*ba[1:0] +: 8] = wdata[8*i +: 8];
                end
            end
            exp_w.push_back({w0, be0, d0});
            if (be1 != 4'd0) exp_w.push_back({w1, be1, d1});
        end
        exp_q.push_back({err, rd, cyc + 32'(lat)});
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        logic [64:0] e;
        #1;
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", {63'd0, bus.resp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", {63'd0, bus.resp_err}, {63'd0, e[64]});
                check("resp_rdata", {32'd0, bus.resp_rdata}, {32'd0, e[63:32]});
                check("resp_latency", {32'd0, cyc}, {32'd0, e[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [50:0] w;
        logic [31:0] m;
        if (rstn && bus.mem_wren) begin
            if (exp_w.size() == 0) begin
                check("write_unexpected", {63'd0, bus.mem_wren}, 64'd0);
            end else begin
                w = exp_w.pop_front();
                m = lane_mask(w[35:32]);
                check("wr_addr", 64'(bus.mem_addr), 64'(w[50:36]));
                check("wr_byteena", 64'(bus.mem_byteena), 64'(w[35:32]));
                check("wr_data", 64'(bus.mem_data & m), 64'(w[31:0] & m));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int t;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rstn  = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        for (int i = 0; i < (1 << AW); i++) fmem[i] = 32'd0;
        for (int i = 0; i < (1 << (AW + 2)); i++) ref_mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
        check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        check("rst_mem_wren", {63'd0, bus.mem_wren}, 64'd0);
        check("rst_mem_byteena", 64'(bus.mem_byteena), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_data", 64'(bus.mem_data), 64'd0);
        rstn = 1'b1;

        do_req(1'b1, SZ_W, 1'b0, 32'h100, 32'hDEADBEEF);
        do_req(1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
        do_req(1'b1, SZ_B, 1'b0, 32'h103, 32'h000000A5);
        do_req(1'b0, SZ_B, 1'b0, 32'h103, 32'h0);
        do_req(1'b0, SZ_B, 1'b1, 32'h103, 32'h0);
        do_req(1'b1, SZ_W, 1'b0, 32'h100, 32'h80017F00);
        do_req(1'b0, SZ_H, 1'b0, 32'h102, 32'h0);
        do_req(1'b0, SZ_H, 1'b1, 32'h102, 32'h0);
        do_req(1'b1, SZ_W, 1'b0, 32'h100, 32'h44332211);
        do_req(1'b1, SZ_W, 1'b0, 32'h104, 32'h88776655);
        do_req(1'b0, SZ_W, 1'b0, 32'h103, 32'h0);
        do_req(1'b1, SZ_H, 1'b0, 32'h1FFFF, 32'h0000BBAA);
        do_req(1'b0, SZ_W, 1'b0, 32'h1FFFC, 32'h0);
        do_req(1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        do_req(1'b1, SZ_W, 1'b0, 32'h1FFFF, 32'h0000BBAA);
        do_req(1'b0, SZ_B, 1'b1, 32'h1FFFF, 32'h0);
        do_req(1'b1, 2'd3, 1'b0, 32'h108, 32'h12345678);
        do_req(1'b0, SZ_W, 1'b0, 32'hFFFE0108, 32'h0);

        // Reset pulsed while a store sits in ACC0: nothing may be written or answered.
        t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_W;
        bus.req_addr = 32'h200; bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("acc0_before_reset", 64'(dbg_state), 64'(ST_ACC0));
        #2 rstn = 1'b0;
        #1;
        check("arst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("arst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("arst_mem_wren", {63'd0, bus.mem_wren}, 64'd0);
        check("arst_mem_byteena", 64'(bus.mem_byteena), 64'd0);
        check("arst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("arst_mem_data", 64'(bus.mem_data), 64'd0);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", {63'd0, bus.req_ready}, 64'd1);
        check("post_reset_state", 64'(dbg_state), 64'(ST_IDLE));
        do_req(1'b0, SZ_W, 1'b0, 32'h200, 32'h0);

        for (int k = 0; k < 300; k++) begin
            a = $urandom & 32'hFFFE0000;
            if ($urandom_range(0, 3) == 0) a[16:0] = 17'h1FFF8 + 17'($urandom_range(0, 7));
            else                           a[16:0] = 17'h100 + 17'($urandom_range(0, 31));
            do_req($urandom_range(0, 1) == 1,
                   ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   $urandom_range(0, 1) == 1, a, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        check("resp_queue_drained", 64'(exp_q.size()), 64'd0);
        check("write_queue_drained", 64'(exp_w.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
